// File: rtl/lsfr_rng_if.sv
// Handshake bundle for lsfr_rng: the start/restart strobe in, the registered
// random value out. S_WIDTH must match the attached lsfr_rng instance.
interface lsfr_rng_if #(
  parameter int S_WIDTH = 8
);
  logic               in_valid;
  logic [S_WIDTH-1:0] random_num_ff_o;

  modport master (
    output in_valid,
    input  random_num_ff_o
  );

  modport slave (
    input  in_valid,
    output random_num_ff_o
  );
endinterface

// File: rtl/lsfr_rng.sv
// Fibonacci LFSR pseudo-random source, seeded from RANDOM_SEED, free-running once started.
// Optional feature macro: LSFR_LOCKUP_GUARD_EN (forces a zero seed/state to 1).
module lsfr_rng #(
  parameter int unsigned S_WIDTH     = 8,
  parameter int unsigned RANDOM_SEED = 8'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  lsfr_rng_if.slave  bus
);

  localparam logic [S_WIDTH-1:0] SEED_RAW = S_WIDTH'(RANDOM_SEED);
  localparam logic [S_WIDTH-1:0] ONE      = {{(S_WIDTH-1){1'b0}}, 1'b1};

`ifdef LSFR_LOCKUP_GUARD_EN
  localparam logic [S_WIDTH-1:0] SEED = (SEED_RAW == '0) ? ONE : SEED_RAW;
`else
  localparam logic [S_WIDTH-1:0] SEED = SEED_RAW;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [S_WIDTH-1:0] lfsr_q;
  logic [S_WIDTH-1:0] lfsr_d;
  logic [S_WIDTH-1:0] lfsr_step;
  logic               fb;

  // Maximal-length taps; tap n refers to lfsr_q[n-1].
  generate
    case (S_WIDTH)
      3:  begin : g_taps3  assign fb = lfsr_q[2]  ^ lfsr_q[1];                          end
      4:  begin : g_taps4  assign fb = lfsr_q[3]  ^ lfsr_q[2];                          end
      5:  begin : g_taps5  assign fb = lfsr_q[4]  ^ lfsr_q[2];                          end
      6:  begin : g_taps6  assign fb = lfsr_q[5]  ^ lfsr_q[4];                          end
      7:  begin : g_taps7  assign fb = lfsr_q[6]  ^ lfsr_q[5];                          end
      8:  begin : g_taps8  assign fb = lfsr_q[7]  ^ lfsr_q[5]  ^ lfsr_q[4] ^ lfsr_q[3]; end
      9:  begin : g_taps9  assign fb = lfsr_q[8]  ^ lfsr_q[4];                          end
      10: begin : g_taps10 assign fb = lfsr_q[9]  ^ lfsr_q[6];                          end
      11: begin : g_taps11 assign fb = lfsr_q[10] ^ lfsr_q[8];                          end
      12: begin : g_taps12 assign fb = lfsr_q[11] ^ lfsr_q[5]  ^ lfsr_q[3] ^ lfsr_q[0]; end
      13: begin : g_taps13 assign fb = lfsr_q[12] ^ lfsr_q[3]  ^ lfsr_q[2] ^ lfsr_q[0]; end
      14: begin : g_taps14 assign fb = lfsr_q[13] ^ lfsr_q[4]  ^ lfsr_q[2] ^ lfsr_q[0]; end
      15: begin : g_taps15 assign fb = lfsr_q[14] ^ lfsr_q[13];                         end
      16: begin : g_taps16 assign fb = lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]; end
      default: begin : g_bad_width
        $fatal(1, "lsfr_rng: S_WIDTH=%0d is outside the supported range 3..16", S_WIDTH);
      end
    endcase
  endgenerate

  assign lfsr_step = {lfsr_q[S_WIDTH-2:0], fb};

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          lfsr_d  = SEED;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          lfsr_d = SEED;
`ifdef LSFR_LOCKUP_GUARD_EN
        end else if (lfsr_q == '0) begin
          lfsr_d = ONE;
`endif
        end else begin
          lfsr_d = lfsr_step;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset reloads the seed so the output shows it before any clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign bus.random_num_ff_o = lfsr_q;

endmodule

// File: tb/tb_lsfr_rng.sv
// Self-checking bench for lsfr_rng: five instances (widths 8 and 3, several seeds)
// checked every cycle against a tap-table model, plus hand-computed literals.
module tb_lsfr_rng;

  localparam int N = 5;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic checkEn;

  int errors;
  int checks;

  lsfr_rng_if #(.S_WIDTH(8)) if0 ();
  lsfr_rng_if #(.S_WIDTH(8)) if1 ();
  lsfr_rng_if #(.S_WIDTH(8)) if2 ();
  lsfr_rng_if #(.S_WIDTH(8)) if3 ();
  lsfr_rng_if #(.S_WIDTH(3)) if4 ();

  assign if0.in_valid = in_valid;
  assign if1.in_valid = in_valid;
  assign if2.in_valid = in_valid;
  assign if3.in_valid = in_valid;
  assign if4.in_valid = in_valid;

  lsfr_rng #(.S_WIDTH(8), .RANDOM_SEED(125)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  lsfr_rng #(.S_WIDTH(8), .RANDOM_SEED(87))  u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  lsfr_rng #(.S_WIDTH(8), .RANDOM_SEED(24))  u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  lsfr_rng #(.S_WIDTH(8), .RANDOM_SEED(0))   u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  lsfr_rng #(.S_WIDTH(3), .RANDOM_SEED(5))   u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  int unsigned dutVal [N];
  always_comb begin
    dutVal[0] = 32'(if0.random_num_ff_o);
    dutVal[1] = 32'(if1.random_num_ff_o);
    dutVal[2] = 32'(if2.random_num_ff_o);
    dutVal[3] = 32'(if3.random_num_ff_o);
    dutVal[4] = 32'(if4.random_num_ff_o);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a tap mask from the 1-indexed table, parity of masked bits is the feedback.
  int          widths [N] = '{8, 8, 8, 8, 3};
  int unsigned seeds  [N] = '{125, 87, 24, 0, 5};
  int unsigned mdlVal [N];
  bit          mdlRun [N];

  function automatic int unsigned tap(int n);
    return 32'd1 << (n - 1);
  endfunction

  function automatic int unsigned tapMask(int w);
    case (w)
      3:  return tap(3) | tap(2);
      4:  return tap(4) | tap(3);
      5:  return tap(5) | tap(3);
      6:  return tap(6) | tap(5);
      7:  return tap(7) | tap(6);
      8:  return tap(8) | tap(6) | tap(5) | tap(4);
      9:  return tap(9) | tap(5);
      10: return tap(10) | tap(7);
      11: return tap(11) | tap(9);
      12: return tap(12) | tap(6) | tap(4) | tap(1);
      13: return tap(13) | tap(4) | tap(3) | tap(1);
      14: return tap(14) | tap(5) | tap(3) | tap(1);
      15: return tap(15) | tap(14);
      16: return tap(16) | tap(15) | tap(13) | tap(4);
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned seedEff(int unsigned s, int w);
    int unsigned t;
    t = s % (32'd1 << w);
`ifdef LSFR_LOCKUP_GUARD_EN
    if (t == 0) t = 1;
`endif
    return t;
  endfunction

  function automatic int unsigned modelStep(int unsigned v, int w);
    int unsigned fb;
`ifdef LSFR_LOCKUP_GUARD_EN
    if (v == 0) return 1;
`endif
    fb = $countones(v & tapMask(w)) % 2;
    return ((v * 2) + fb) % (32'd1 << w);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        mdlVal[i] <= seedEff(seeds[i], widths[i]);
        mdlRun[i] <= 1'b0;
      end else if (in_valid) begin
        mdlVal[i] <= seedEff(seeds[i], widths[i]);
        mdlRun[i] <= 1'b1;
      end else if (mdlRun[i]) begin
        mdlVal[i] <= modelStep(mdlVal[i], widths[i]);
      end
    end
  end

  task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      in_valid = v;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < N; i++)
        checkOutput($sformatf("model_u%0d", i), dutVal[i], mdlVal[i]);
    end
  end

  bit          seen [3][256];
  bit          fresh;
  int unsigned zeroExp;

  initial begin
    errors   = 0;
    checks   = 0;
    checkEn  = 1'b0;
    in_valid = 1'b0;
    rst_n    = 1'b0;
`ifdef LSFR_LOCKUP_GUARD_EN
    zeroExp = 1;
`else
    zeroExp = 0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset_u0", dutVal[0], 125);
    checkOutput("reset_u3", dutVal[3], zeroExp);
    rst_n   = 1'b1;
    checkEn = 1'b1;

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("idle_hold", dutVal[0], 125);
    end

    applyStimulus(1'b1, 1);
    checkOutput("pulse_u0_0", dutVal[0], 125);
    checkOutput("pulse_u3_0", dutVal[3], zeroExp);
    checkOutput("pulse_u4_0", dutVal[4], 5);
    @(negedge clk);
    checkOutput("pulse_u0_1", dutVal[0], 251);
    checkOutput("pulse_u3_1", dutVal[3], zeroExp * 2);
    checkOutput("pulse_u4_1", dutVal[4], 3);
    @(negedge clk);
    checkOutput("pulse_u0_2", dutVal[0], 246);
    checkOutput("pulse_u3_2", dutVal[3], zeroExp * 4);
    checkOutput("pulse_u4_2", dutVal[4], 7);
    @(negedge clk);
    checkOutput("pulse_u0_3", dutVal[0], 237);
    checkOutput("pulse_u3_3", dutVal[3], zeroExp * 8);
    checkOutput("pulse_u4_3", dutVal[4], 6);

    // Full-period walk of the three 8-bit streams from a fresh start.
    applyStimulus(1'b1, 1);
    for (int s = 0; s < 3; s++) begin
      for (int v = 0; v < 256; v++) seen[s][v] = 1'b0;
      seen[s][dutVal[s]] = 1'b1;
    end
    for (int k = 1; k <= 255; k++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        if (k < 255) begin
          fresh = (dutVal[s] != 0) && !seen[s][dutVal[s] % 256];
          if (!fresh)
            checkOutput($sformatf("unique_u%0d_step%0d", s, k), dutVal[s], 999);
          seen[s][dutVal[s] % 256] = 1'b1;
        end else begin
          checkOutput($sformatf("period_u%0d", s), dutVal[s], seeds[s]);
        end
      end
    end

    repeat (5) @(negedge clk);
    applyStimulus(1'b1, 1);
    checkOutput("restart_0", dutVal[0], 125);
    @(negedge clk);
    checkOutput("restart_1", dutVal[0], 251);

    applyStimulus(1'b1, 3);
    checkOutput("hold_valid", dutVal[0], 125);
    @(negedge clk);
    checkOutput("hold_release", dutVal[0], 251);

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", dutVal[0], 125);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("idle_after_reset", dutVal[0], 125);
    end
    applyStimulus(1'b1, 1);
    checkOutput("after_reset_0", dutVal[0], 125);
    @(negedge clk);
    checkOutput("after_reset_1", dutVal[0], 251);

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
